dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory, including its memory-mapped display registers at 0x1000 and 0x1004.
- Port 0 is the CPU data port. Port 1 is a secondary master, such as a loader or debug engine.
- Serialises accesses with round-robin fairness and a req/ack handshake.
- Drives the memory's memwrite/adr/writedata inputs and captures its combinational read data.

Parameters:
WIDTH, 32, data and address width of every bus.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  port 0 request; held high until ack0
we0  input  1  port 0 write enable (1 = write, 0 = read); stable while req0
adr0  input  WIDTH  port 0 byte address; stable while req0
wdata0  input  WIDTH  port 0 write data; stable while req0
ack0  output  1  port 0 completion strobe, one cycle
err0  output  1  port 0 misaligned-access flag, valid with ack0
rdata0  output  WIDTH  port 0 read data, valid with ack0 and held until the next port 0 ack
req1, we1, adr1, wdata1, ack1, err1, rdata1  same as port 0, for port 1
mem_we  output  1  to memory memwrite
mem_adr  output  WIDTH  to memory adr
mem_wdata  output  WIDTH  to memory writedata
mem_rdata  input  WIDTH  from memory memdata (combinational from mem_adr)
busy  output  1  high in any state other than IDLE

Behaviour:
Reset values:
- All outputs are 0.
- FSM = IDLE.
- Round-robin pointer last = 1, so port 0 wins the first contention.
- Reset asserted in any state aborts the transaction: no ack is issued and mem_we falls the next cycle.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- No request: stay.
- One request: grant it.
- Both requesting: grant the port != last.
- On grant:
  - Register sel, adr, we, wdata into mem_adr/mem_wdata.
  - Compute mis = (adr[1:0] != 0).
  - Go to ACCESS.
- mem_we = 0 in IDLE.

ACCESS (exactly one cycle):
- mem_we = we & ~mis, so it is high for one cycle only.
- A read with ~mis captures mem_rdata into rdata[sel] at the end of the cycle.
- A misaligned access captures 0 instead, and memory is untouched.
- Go to DONE.

DONE (one cycle):
- ack[sel] = 1 and err[sel] = mis. The other port's ack and err stay 0.
- last <= sel.
- Go to IDLE.

Latency and throughput:
- Request sampled in IDLE cycle t gives mem access in t+1 and ack in t+2.
- Throughput is one transaction per 3 cycles.
- Uncontended back-to-back requests from one port are each serviced 3 cycles apart.

Handshake rules:
- A requester keeps req, we, adr and wdata stable from assertion through its ack cycle.
- It deasserts req in the cycle after ack, or keeps it asserted to issue a new request.
- Because IDLE follows DONE, a req still high in IDLE after ack is treated as a new request.
- A req that drops before ack is a protocol violation: the transaction still completes and acks.

Other rules:
- Arbitration happens only in IDLE. A new request arriving during ACCESS or DONE waits.
- No combinational path from req or adr to mem_* outputs. mem_adr and mem_wdata are registered and hold their last value in IDLE.
- rdata of a write transaction is unchanged, so the previous read data is held.
- MMIO addresses (0x1000, 0x1004) are passed through like any other aligned address. No special decode happens here.

Test Plan:
- Reset, then port 0 read of adr 0x8 with memory word 2 = 0xDEADBEEF -> mem_adr=0x8 with mem_we=0 in cycle 1; ack0=1, rdata0=0xDEADBEEF, err0=0 in cycle 2; ack1 stays 0.
- Port 1 write adr 0x1000 data 0x00005678 -> mem_we high exactly one cycle with mem_adr=0x1000 and mem_wdata=0x5678; ack1 one cycle later; busy high for 2 cycles.
- req0 and req1 both asserted from the first cycle after reset, held continuously -> grants alternate 0,1,0,1. Acks appear every 3 cycles, starting with ack0.
- Port 0 write to adr 0x6 -> mem_we never asserts; ack0=1 with err0=1. A subsequent read of 0x4 returns the unchanged memory value.
- reset pulsed during the ACCESS cycle of a port 1 write -> no ack1. busy=0 and mem_we=0 the cycle after reset. The next contended request goes to port 0.
- req1 asserted while a port 0 transaction is in ACCESS -> port 1 is granted in the IDLE cycle immediately following ack0; ack1 comes 3 cycles after ack0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every bus signal of the data-memory arbiter: two requester ports
// (req/we/adr/wdata in, ack/err/rdata out), the single-port memory interface
// (mem_we/mem_adr/mem_wdata out, mem_rdata in) and the busy status flag.
//   slave  : the arbiter's view (drives ack/err/rdata, mem_*, busy)
//   master : the surrounding system's view (requesters and the memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int WIDTH = 32
);
  // Requester port 0 (CPU data port)
  logic             req0;
  logic             we0;
  logic [WIDTH-1:0] adr0;
  logic [WIDTH-1:0] wdata0;
  logic             ack0;
  logic             err0;
  logic [WIDTH-1:0] rdata0;

  // Requester port 1 (loader / debug engine)
  logic             req1;
  logic             we1;
  logic [WIDTH-1:0] adr1;
  logic [WIDTH-1:0] wdata1;
  logic             ack1;
  logic             err1;
  logic [WIDTH-1:0] rdata1;

  // Single-port memory
  logic             mem_we;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  // Status
  logic             busy;

  modport slave (
    input  req0, we0, adr0, wdata0,
    output ack0, err0, rdata0,
    input  req1, we1, adr1, wdata1,
    output ack1, err1, rdata1,
    output mem_we, mem_adr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output req0, we0, adr0, wdata0,
    input  ack0, err0, rdata0,
    output req1, we1, adr1, wdata1,
    input  ack1, err1, rdata1,
    input  mem_we, mem_adr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Round-robin arbiter placing two requesters onto one single-port data
// memory (including the display registers at 0x1000/0x1004, which need no
// special handling here). Each transaction takes IDLE -> ACCESS -> DONE:
// grant in IDLE, one memory cycle in ACCESS, one-cycle ack in DONE.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; aborts any transaction in flight
//   bus   : dmem_arbiter_if.slave - requester ports 0/1, memory bus, busy
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Transaction context captured at grant time
  logic             sel_q, sel_d;     // granted port
  logic             we_q, we_d;
  logic             mis_q, mis_d;     // misaligned address
  logic             last_q, last_d;   // last port serviced (round-robin)
  logic [WIDTH-1:0] mem_adr_q, mem_adr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Per-port read data, held until that port's next read completes
  logic [WIDTH-1:0] rdata_q [2];

  // Requester ports gathered into arrays so the grant can index them
  logic [1:0]       req_w;
  logic [1:0]       we_w;
  logic [WIDTH-1:0] adr_w   [2];
  logic [WIDTH-1:0] wdata_w [2];
  logic [1:0]       ack_w;
  logic [1:0]       err_w;

  logic             grant;

  assign req_w      = {bus.req1, bus.req0};
  assign we_w       = {bus.we1, bus.we0};
  assign adr_w[0]   = bus.adr0;
  assign adr_w[1]   = bus.adr1;
  assign wdata_w[0] = bus.wdata0;
  assign wdata_w[1] = bus.wdata1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    we_d        = we_q;
    mis_d       = mis_q;
    last_d      = last_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    grant       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_w != 2'b00) begin
          // Contention goes to the port that was not serviced last;
          // otherwise the single requester wins.
          if (req_w == 2'b11) begin
            grant = ~last_q;
          end else begin
            grant = req_w[1];
          end
          sel_d       = grant;
          we_d        = we_w[grant];
          mem_adr_d   = adr_w[grant];
          mem_wdata_d = wdata_w[grant];
          mis_d       = (adr_w[grant][1:0] != 2'b00);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DONE;
      end
      DONE: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and context registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      last_q      <= 1'b1;   // port 0 wins the first contention
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      mis_q       <= mis_d;
      last_q      <= last_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Read data capture at the end of ACCESS. A misaligned read returns 0;
  // writes leave the previous read data in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rdata_q[i] <= '0;
      end
    end else if ((state_q == ACCESS) && !we_q) begin
      rdata_q[sel_q] <= mis_q ? '0 : bus.mem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state, so nothing combinational
  // runs from the requester inputs to the memory bus.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ack_w[gi] = (state_q == DONE) && (sel_q == 1'(gi));
    assign err_w[gi] = (state_q == DONE) && (sel_q == 1'(gi)) && mis_q;
  end

  assign bus.ack0   = ack_w[0];
  assign bus.err0   = err_w[0];
  assign bus.rdata0 = rdata_q[0];
  assign bus.ack1   = ack_w[1];
  assign bus.err1   = err_w[1];
  assign bus.rdata1 = rdata_q[1];

  // Write strobe lasts exactly the one ACCESS cycle and is suppressed for
  // misaligned addresses so memory is never touched by them.
  assign bus.mem_we    = (state_q == ACCESS) && we_q && !mis_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small word memory plus the two
// display registers modelled alongside. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk;
  logic reset;

  dmem_arbiter_if #(.WIDTH(32)) bus ();

  dmem_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 16 words plus display registers at 0x1000 / 0x1004
  logic [31:0] mem [16];
  logic [31:0] disp0;
  logic [31:0] disp1;

  always_comb begin
    if (bus.mem_adr == 32'h1000)      bus.mem_rdata = disp0;
    else if (bus.mem_adr == 32'h1004) bus.mem_rdata = disp1;
    else                              bus.mem_rdata = mem[bus.mem_adr[5:2]];
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_adr == 32'h1000)      disp0 <= bus.mem_wdata;
      else if (bus.mem_adr == 32'h1004) disp1 <= bus.mem_wdata;
      else                              mem[bus.mem_adr[5:2]] <= bus.mem_wdata;
    end
  end

  int n_cmp;
  int n_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.adr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.adr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    n_cmp++; if (bus.ack0 !== 1'b0) begin n_bad++; $display("FAIL reset_ack0: got %b want 0", bus.ack0); end
    n_cmp++; if (bus.ack1 !== 1'b0) begin n_bad++; $display("FAIL reset_ack1: got %b want 0", bus.ack1); end
    n_cmp++; if (bus.err0 !== 1'b0) begin n_bad++; $display("FAIL reset_err0: got %b want 0", bus.err0); end
    n_cmp++; if (bus.err1 !== 1'b0) begin n_bad++; $display("FAIL reset_err1: got %b want 0", bus.err1); end
    n_cmp++; if (bus.rdata0 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata0: got %h want 0", bus.rdata0); end
    n_cmp++; if (bus.rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h want 0", bus.rdata1); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.mem_adr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_adr: got %h want 0", bus.mem_adr); end
    n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    reset = 0;
    $display("reset: done");
  endtask

  task automatic test_read();
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 32'h8;
    tick();  // ACCESS
    n_cmp++; if (bus.mem_adr !== 32'h8) begin n_bad++; $display("FAIL read_mem_adr: got %h want 00000008", bus.mem_adr); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL read_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.ack0 !== 1'b0) begin n_bad++; $display("FAIL read_early_ack0: got %b want 0", bus.ack0); end
    tick();  // DONE
    n_cmp++; if (bus.ack0 !== 1'b1) begin n_bad++; $display("FAIL read_ack0: got %b want 1", bus.ack0); end
    n_cmp++; if (bus.rdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_rdata0: got %h want deadbeef", bus.rdata0); end
    n_cmp++; if (bus.err0 !== 1'b0) begin n_bad++; $display("FAIL read_err0: got %b want 0", bus.err0); end
    n_cmp++; if (bus.ack1 !== 1'b0) begin n_bad++; $display("FAIL read_ack1: got %b want 0", bus.ack1); end
    tick();  // IDLE
    bus.req0 = 0;
    n_cmp++; if (bus.ack0 !== 1'b0) begin n_bad++; $display("FAIL read_ack0_pulse: got %b want 0", bus.ack0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_idle: got %b want 0", bus.busy); end
    $display("read: port0 adr 0x8 rdata0=%h", bus.rdata0);
  endtask

  task automatic test_write();
    int we_cycles;
    int busy_cycles;
    int ack_tick;
    we_cycles = 0; busy_cycles = 0; ack_tick = -1;
    bus.req1 = 1; bus.we1 = 1; bus.adr1 = 32'h1000; bus.wdata1 = 32'h0000_5678;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 3) bus.req1 = 0;  // IDLE after ack: release
      if (bus.mem_we) begin
        we_cycles++;
        n_cmp++; if (bus.mem_adr !== 32'h1000) begin n_bad++; $display("FAIL write_mem_adr: got %h want 00001000", bus.mem_adr); end
        n_cmp++; if (bus.mem_wdata !== 32'h5678) begin n_bad++; $display("FAIL write_mem_wdata: got %h want 00005678", bus.mem_wdata); end
        n_cmp++; if (i !== 1) begin n_bad++; $display("FAIL write_we_tick: got %0d want 1", i); end
      end
      if (bus.busy) busy_cycles++;
      if (bus.ack1) begin
        ack_tick = i;
        n_cmp++; if (bus.err1 !== 1'b0) begin n_bad++; $display("FAIL write_err1: got %b want 0", bus.err1); end
        n_cmp++; if (bus.rdata1 !== 32'h0) begin n_bad++; $display("FAIL write_rdata1_held: got %h want 0", bus.rdata1); end
      end
      n_cmp++; if (bus.ack0 !== 1'b0) begin n_bad++; $display("FAIL write_ack0: got %b want 0", bus.ack0); end
    end
    n_cmp++; if (we_cycles !== 1) begin n_bad++; $display("FAIL write_we_cycles: got %0d want 1", we_cycles); end
    n_cmp++; if (busy_cycles !== 2) begin n_bad++; $display("FAIL write_busy_cycles: got %0d want 2", busy_cycles); end
    n_cmp++; if (ack_tick !== 2) begin n_bad++; $display("FAIL write_ack_tick: got %0d want 2", ack_tick); end
    n_cmp++; if (disp0 !== 32'h5678) begin n_bad++; $display("FAIL write_disp0: got %h want 00005678", disp0); end
    $display("write: port1 adr 0x1000 disp0=%h ack at tick %0d", disp0, ack_tick);
  endtask

  task automatic test_contention();
    logic exp0;
    logic exp1;
    reset = 1;
    tick();
    reset = 0;
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 32'h0;
    bus.req1 = 1; bus.we1 = 0; bus.adr1 = 32'h4;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 12) begin bus.req0 = 0; bus.req1 = 0; end
      exp0 = (i % 3 == 2) && ((i / 3) % 2 == 0);
      exp1 = (i % 3 == 2) && ((i / 3) % 2 == 1);
      n_cmp++; if (bus.ack0 !== exp0) begin n_bad++; $display("FAIL rr_ack0 t%0d: got %b want %b", i, bus.ack0, exp0); end
      n_cmp++; if (bus.ack1 !== exp1) begin n_bad++; $display("FAIL rr_ack1 t%0d: got %b want %b", i, bus.ack1, exp1); end
      if (exp0) begin
        n_cmp++; if (bus.rdata0 !== 32'h0A0A_0000) begin n_bad++; $display("FAIL rr_rdata0 t%0d: got %h want 0a0a0000", i, bus.rdata0); end
      end
      if (exp1) begin
        n_cmp++; if (bus.rdata1 !== 32'h1111_2222) begin n_bad++; $display("FAIL rr_rdata1 t%0d: got %h want 11112222", i, bus.rdata1); end
      end
      if (bus.ack0 || bus.ack1) $display("contention: t%0d ack0=%b ack1=%b", i, bus.ack0, bus.ack1);
    end
  endtask

  task automatic test_misaligned();
    bus.req0 = 1; bus.we0 = 1; bus.adr0 = 32'h6; bus.wdata0 = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL mis_mem_we: got %b want 0", bus.mem_we); end
    tick();
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL mis_mem_we_done: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.ack0 !== 1'b1) begin n_bad++; $display("FAIL mis_ack0: got %b want 1", bus.ack0); end
    n_cmp++; if (bus.err0 !== 1'b1) begin n_bad++; $display("FAIL mis_err0: got %b want 1", bus.err0); end
    n_cmp++; if (bus.rdata0 !== 32'h0A0A_0000) begin n_bad++; $display("FAIL mis_rdata0_held: got %h want 0a0a0000", bus.rdata0); end
    n_cmp++; if (bus.err1 !== 1'b0) begin n_bad++; $display("FAIL mis_err1: got %b want 0", bus.err1); end
    tick();
    bus.req0 = 0;
    n_cmp++; if (bus.err0 !== 1'b0) begin n_bad++; $display("FAIL mis_err0_pulse: got %b want 0", bus.err0); end
    $display("misaligned write: adr 0x6 err0 seen");
    // Aligned read of the neighbouring word: must be untouched
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 32'h4;
    tick();
    tick();
    n_cmp++; if (bus.ack0 !== 1'b1) begin n_bad++; $display("FAIL mis_rd_ack0: got %b want 1", bus.ack0); end
    n_cmp++; if (bus.err0 !== 1'b0) begin n_bad++; $display("FAIL mis_rd_err0: got %b want 0", bus.err0); end
    n_cmp++; if (bus.rdata0 !== 32'h1111_2222) begin n_bad++; $display("FAIL mis_rd_rdata0: got %h want 11112222", bus.rdata0); end
    tick();
    bus.req0 = 0;
    // Misaligned read returns zero with err
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 32'h9;
    tick();
    tick();
    n_cmp++; if (bus.err0 !== 1'b1) begin n_bad++; $display("FAIL misrd_err0: got %b want 1", bus.err0); end
    n_cmp++; if (bus.rdata0 !== 32'h0) begin n_bad++; $display("FAIL misrd_rdata0: got %h want 0", bus.rdata0); end
    tick();
    bus.req0 = 0;
    $display("misaligned read: adr 0x9 rdata0=%h", bus.rdata0);
  endtask

  task automatic test_reset_abort();
    bus.req1 = 1; bus.we1 = 1; bus.adr1 = 32'hC; bus.wdata1 = 32'h0000_CAFE;
    tick();  // ACCESS
    n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL abort_we_access: got %b want 1", bus.mem_we); end
    reset = 1;
    tick();
    reset = 0;
    bus.req1 = 0;
    n_cmp++; if (bus.ack1 !== 1'b0) begin n_bad++; $display("FAIL abort_ack1: got %b want 0", bus.ack1); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL abort_mem_we: got %b want 0", bus.mem_we); end
    tick();
    n_cmp++; if (bus.ack1 !== 1'b0) begin n_bad++; $display("FAIL abort_ack1_late: got %b want 0", bus.ack1); end
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 32'h0;
    bus.req1 = 1; bus.we1 = 0; bus.adr1 = 32'h4;
    tick();
    n_cmp++; if (bus.mem_adr !== 32'h0) begin n_bad++; $display("FAIL abort_grant_adr: got %h want 0", bus.mem_adr); end
    tick();
    n_cmp++; if (bus.ack0 !== 1'b1) begin n_bad++; $display("FAIL abort_next_ack0: got %b want 1", bus.ack0); end
    n_cmp++; if (bus.ack1 !== 1'b0) begin n_bad++; $display("FAIL abort_next_ack1: got %b want 0", bus.ack1); end
    tick();
    bus.req0 = 0; bus.req1 = 0;
    $display("reset abort: port1 write dropped, port0 granted next");
  endtask

  task automatic test_late_req();
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 32'h8;
    tick();  // ACCESS for port 0
    bus.req1 = 1; bus.we1 = 0; bus.adr1 = 32'h4;
    tick();  // DONE
    n_cmp++; if (bus.ack0 !== 1'b1) begin n_bad++; $display("FAIL late_ack0: got %b want 1", bus.ack0); end
    n_cmp++; if (bus.ack1 !== 1'b0) begin n_bad++; $display("FAIL late_ack1_early: got %b want 0", bus.ack1); end
    tick();  // IDLE: port 1 gets sampled here
    bus.req0 = 0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL late_idle_busy: got %b want 0", bus.busy); end
    tick();  // ACCESS for port 1
    n_cmp++; if (bus.mem_adr !== 32'h4) begin n_bad++; $display("FAIL late_mem_adr: got %h want 00000004", bus.mem_adr); end
    n_cmp++; if (bus.ack1 !== 1'b0) begin n_bad++; $display("FAIL late_ack1_access: got %b want 0", bus.ack1); end
    tick();  // DONE, 3 cycles after ack0
    n_cmp++; if (bus.ack1 !== 1'b1) begin n_bad++; $display("FAIL late_ack1: got %b want 1", bus.ack1); end
    n_cmp++; if (bus.rdata1 !== 32'h1111_2222) begin n_bad++; $display("FAIL late_rdata1: got %h want 11112222", bus.rdata1); end
    tick();
    bus.req1 = 0;
    $display("late request: port1 acked 3 cycles after port0");
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 32'h8;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 6) bus.req0 = 0;
      n_cmp++; if (bus.ack0 !== ((i % 3) == 2)) begin n_bad++; $display("FAIL b2b_ack0 t%0d: got %b want %b", i, bus.ack0, ((i % 3) == 2)); end
      if (bus.ack0) acks++;
    end
    n_cmp++; if (acks !== 2) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 2", acks); end
    $display("back to back: port0 %0d acks in 6 cycles", acks);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h0A0A_0000;
    mem[1] = 32'h1111_2222;
    mem[2] = 32'hDEAD_BEEF;
    disp0 = 32'h0;
    disp1 = 32'h0;

    test_reset();
    test_read();
    test_write();
    test_contention();
    test_misaligned();
    test_reset_abort();
    test_late_req();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
